// File: rtl/ysyx_24100006_id_pkg.sv
// Shared ID-stage definitions: immediate type codes and the
// state encoding used by the pipelined immediate generator.
package ysyx_24100006_id_pkg;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_J     = 3'b001;
    localparam logic [2:0] IMM_S     = 3'b010;
    localparam logic [2:0] IMM_B     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_Z     = 3'b101;
    localparam logic [2:0] IMM_SHAMT = 3'b110;
    localparam logic [2:0] IMM_ILL   = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/ysyx_24100006_imm_extract.sv
// Combinational immediate extraction: (instruction, type) -> XLEN immediate
// plus an illegal-type flag. Shared with the decoder's unregistered paths.
module ysyx_24100006_imm_extract
    import ysyx_24100006_id_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RVE_SHAMT6 = 1
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    localparam bit SHAMT_WIDE = (XLEN == 64) && (RVE_SHAMT6 == 1);

    // Every format is first built as a 32-bit value whose bit 31 already
    // carries the correct extension bit (inst[31] for sext, 0 for zext).
    logic [31:0] imm32;
    logic        unused_opcode;

    assign unused_opcode = ^inst[6:0];

    always_comb begin
        imm32 = '0;
        err   = 1'b0;
        unique case (imm_type)
            IMM_I:     imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_J:     imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_S:     imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:     imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:     imm32 = {inst[31:12], 12'b0};
            IMM_Z:     imm32 = {27'b0, inst[19:15]};
            IMM_SHAMT: imm32 = SHAMT_WIDE ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
            default: begin
                imm32 = '0;
                err   = 1'b1;
            end
        endcase
    end

    generate
        if (XLEN > 32) begin : g_wide
            assign imm = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_narrow
            assign imm = imm32[XLEN-1:0];
        end
    endgenerate

endmodule

// File: rtl/ysyx_24100006_imm_gen_pipe.sv
// Registered immediate generator with a two-entry skid buffer so that
// in_ready depends only on state, never combinationally on out_ready.
module ysyx_24100006_imm_gen_pipe
    import ysyx_24100006_id_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 32,
    parameter int RVE_SHAMT6 = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    state_t state_reg, state_next;

    logic [XLEN-1:0]  main_imm_reg, skid_imm_reg, new_imm;
    logic [TAG_W-1:0] main_tag_reg, skid_tag_reg;
    logic             main_err_reg, skid_err_reg, new_err;

    logic accept, out_fire;
    logic load_main_new, load_main_skid, load_skid;

    ysyx_24100006_imm_extract #(
        .XLEN       (XLEN),
        .RVE_SHAMT6 (RVE_SHAMT6)
    ) u_extract (
        .inst     (in_inst),
        .imm_type (in_type),
        .imm      (new_imm),
        .err      (new_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_EMPTY: if (accept) state_next = ST_ONE;
            ST_ONE: begin
                if (accept && !out_fire)      state_next = ST_TWO;
                else if (!accept && out_fire) state_next = ST_EMPTY;
            end
            ST_TWO:   if (out_fire) state_next = ST_ONE;
            default:  state_next = ST_EMPTY;
        endcase
        if (flush) state_next = ST_EMPTY;
    end

    always_comb begin
        in_ready       = (state_reg != ST_TWO);
        out_valid      = (state_reg != ST_EMPTY);
        out_fire       = out_valid && out_ready;
        // A flushed offer is dropped even though in_ready is high.
        accept         = in_valid && in_ready && !flush;
        load_main_new  = accept && ((state_reg == ST_EMPTY) || ((state_reg == ST_ONE) && out_fire));
        load_skid      = accept && (state_reg == ST_ONE) && !out_fire;
        load_main_skid = !flush && out_fire && (state_reg == ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_imm_reg <= '0;
            main_tag_reg <= '0;
            main_err_reg <= 1'b0;
        end else if (load_main_new) begin
            main_imm_reg <= new_imm;
            main_tag_reg <= in_tag;
            main_err_reg <= new_err;
        end else if (load_main_skid) begin
            main_imm_reg <= skid_imm_reg;
            main_tag_reg <= skid_tag_reg;
            main_err_reg <= skid_err_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_imm_reg <= '0;
            skid_tag_reg <= '0;
            skid_err_reg <= 1'b0;
        end else if (load_skid) begin
            skid_imm_reg <= new_imm;
            skid_tag_reg <= in_tag;
            skid_err_reg <= new_err;
        end
    end

    assign out_imm = main_imm_reg;
    assign out_tag = main_tag_reg;
    assign out_err = main_err_reg;

endmodule

// File: tb/tb_ysyx_24100006_imm_gen_pipe.sv
// Directed bench: an XLEN=64 and an XLEN=32 instance share one stimulus
// stream; expected values are hand-computed from the instruction encodings.
module tb_ysyx_24100006_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [2:0]  in_type = '0;
    logic [31:0] in_tag = '0;
    logic        out_ready = 1'b0;

    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;
    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32;
    logic [31:0] out_tag32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_24100006_imm_gen_pipe #(.XLEN(64), .TAG_W(32), .RVE_SHAMT6(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
    );

    ysyx_24100006_imm_gen_pipe #(.XLEN(32), .TAG_W(32), .RVE_SHAMT6(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One streaming transfer with out_ready=1: offer, clock, check result.
    task automatic xfer(input string name, input logic [31:0] inst, input logic [2:0] ty,
                        input logic [31:0] tag, input logic [63:0] exp64,
                        input logic [31:0] exp32, input logic exp_err);
        in_valid = 1'b1; in_inst = inst; in_type = ty; in_tag = tag;
        tick();
        $display("xfer %s inst=%h type=%0d imm64=%h imm32=%h err=%0b", name, inst, ty,
                 out_imm64, out_imm32, out_err64);
        check({name, "_valid"}, {63'b0, out_valid64}, 64'd1);
        check({name, "_imm64"}, out_imm64, exp64);
        check({name, "_imm32"}, {32'b0, out_imm32}, {32'b0, exp32});
        check({name, "_tag"}, {32'b0, out_tag64}, {32'b0, tag});
        check({name, "_err"}, {62'b0, out_err64, out_err32}, {62'b0, exp_err, exp_err});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {62'b0, out_valid64, out_valid32}, 64'd0);
        check("rst_ready", {62'b0, in_ready64, in_ready32}, 64'd3);
        check("rst_imm", out_imm64, 64'd0);
        check("rst_tag", {32'b0, out_tag64}, 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;

        xfer("i_neg", 32'hFFF00093, 3'd0, 32'h80000000, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        xfer("i_pos", 32'h7FF00093, 3'd0, 32'h1, 64'h7FF, 32'h7FF, 1'b0);
        xfer("j",     32'h0080006F, 3'd1, 32'h2, 64'h8, 32'h8, 1'b0);
        xfer("s",     32'hFE112E23, 3'd2, 32'h3, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 1'b0);
        xfer("b",     32'hFE000EE3, 3'd3, 32'h4, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, 1'b0);
        xfer("u_neg", 32'h80000037, 3'd4, 32'h5, 64'hFFFFFFFF80000000, 32'h80000000, 1'b0);
        xfer("u_pos", 32'h12345037, 3'd4, 32'h6, 64'h0000000012345000, 32'h12345000, 1'b0);
        xfer("z",     32'h000FD073, 3'd5, 32'h7, 64'h1F, 32'h1F, 1'b0);
        xfer("shamt", 32'h03F0D093, 3'd6, 32'h8, 64'h3F, 32'h1F, 1'b0);
        xfer("ill",   32'hFFFFFFFF, 3'd7, 32'h9, 64'h0, 32'h0, 1'b1);

        in_valid = 1'b0;
        tick();
        check("drain_valid", {63'b0, out_valid64}, 64'd0);

        // Back-pressure: A, B, C offered while downstream stalls.
        out_ready = 1'b0;
        in_valid = 1'b1; in_type = 3'd0;
        in_inst = 32'h00100093; in_tag = 32'hA;
        tick();
        check("bp_a_ready", {63'b0, in_ready64}, 64'd1);
        check("bp_a_tag", {32'b0, out_tag64}, 64'hA);
        in_inst = 32'h00200093; in_tag = 32'hB;
        tick();
        check("bp_b_ready", {63'b0, in_ready64}, 64'd0);
        check("bp_b_tag", {32'b0, out_tag64}, 64'hA);
        in_inst = 32'h00300093; in_tag = 32'hC;
        tick();
        check("bp_c_held", {62'b0, in_ready64, in_ready32}, 64'd0);
        check("bp_hold_imm", out_imm64, 64'd1);
        out_ready = 1'b1;
        tick();
        $display("xfer bp_b tag=%h imm=%h", out_tag64, out_imm64);
        check("bp_b_out_tag", {32'b0, out_tag64}, 64'hB);
        check("bp_b_out_imm", out_imm64, 64'd2);
        check("bp_b_out_ready", {63'b0, in_ready64}, 64'd1);
        tick();
        in_valid = 1'b0;
        $display("xfer bp_c tag=%h imm=%h", out_tag64, out_imm64);
        check("bp_c_out_valid", {63'b0, out_valid64}, 64'd1);
        check("bp_c_out_tag", {32'b0, out_tag64}, 64'hC);
        check("bp_c_out_imm", out_imm64, 64'd3);
        tick();
        check("bp_empty", {63'b0, out_valid64}, 64'd0);

        // Flush in state TWO with a new offer present.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00400093; in_tag = 32'hD;
        tick();
        in_inst = 32'h00500093; in_tag = 32'hE;
        tick();
        check("fl_two", {63'b0, in_ready64}, 64'd0);
        in_inst = 32'h00600093; in_tag = 32'hF; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        $display("xfer flush valid=%0b ready=%0b", out_valid64, in_ready64);
        check("fl_valid", {62'b0, out_valid64, out_valid32}, 64'd0);
        check("fl_ready", {62'b0, in_ready64, in_ready32}, 64'd3);
        out_ready = 1'b1;
        tick();
        check("fl_stay_empty", {63'b0, out_valid64}, 64'd0);
        xfer("post_flush", 32'h00700093, 3'd0, 32'h77, 64'h7, 32'h7, 1'b0);
        in_valid = 1'b0;
        tick();

        // Asynchronous reset in state TWO.
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'h11;
        tick();
        in_tag = 32'h22;
        tick();
        check("ar_two", {63'b0, in_ready64}, 64'd0);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        $display("xfer async_reset valid=%0b imm=%h", out_valid64, out_imm64);
        check("ar_valid", {62'b0, out_valid64, out_valid32}, 64'd0);
        check("ar_imm", out_imm64, 64'd0);
        check("ar_tag", {32'b0, out_tag64}, 64'd0);
        check("ar_ready", {63'b0, in_ready64}, 64'd1);
        tick();
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        xfer("after_rst", 32'h12345037, 3'd4, 32'h33, 64'h12345000, 32'h12345000, 1'b0);
        in_valid = 1'b0;
        tick();
        check("final_empty", {63'b0, out_valid64}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24100006_imm_gen_pipe.md
Name: ysyx_24100006_imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the ID stage. It accepts an instruction word and an immediate-type code over a valid/ready handshake. One cycle later it returns the sign- or zero-extended immediate at XLEN width, together with a pass-through tag (typically the PC).
It adds CSR zimm, shift-amount and illegal-type detection. A two-entry skid buffer decouples the upstream ready path from downstream back-pressure.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
TAG_W, 32, width of the side-band tag carried alongside each instruction
RVE_SHAMT6, 1, when 1 and XLEN==64, SHAMT type uses inst[25:20]; otherwise inst[24:20]

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush; discards all held and incoming entries
in_valid  in  1  upstream entry valid
in_ready  out  1  block can accept an entry this cycle
in_inst  in  32  raw instruction word
in_type  in  3  immediate type code (see Behaviour)
in_tag  in  TAG_W  side-band tag, returned unmodified
out_valid  out  1  output entry valid
out_ready  in  1  downstream accepts the entry
out_imm  out  XLEN  extended immediate
out_tag  out  TAG_W  tag of the presented entry
out_err  out  1  presented entry had illegal type code

Behaviour:
- Type codes:
  - 000 I: sext(inst[31:20])
  - 001 J: sext({inst[31],inst[19:12],inst[20],inst[30:21],0})
  - 010 S: sext({inst[31:25],inst[11:7]})
  - 011 B: sext({inst[31],inst[7],inst[30:25],inst[11:8],0})
  - 100 U: sext({inst[31:12],12'b0})
  - 101 Z: zext(inst[19:15])
  - 110 SHAMT: zext(inst[25:20]) if XLEN==64 and RVE_SHAMT6, else zext(inst[24:20])
  - 111: imm=0 and err=1
- Extension rules:
  - sext replicates inst[31] up to bit XLEN-1.
  - zext fills with zeros.
  - err=0 for all types other than 111.
- Handshake:
  - Input fire = in_valid & in_ready.
  - Output fire = out_valid & out_ready.
  - Once out_valid is asserted, out_imm, out_tag and out_err stay stable until output fire.
- Storage: two entries, a main register and a skid register. Each entry holds imm, tag and err, computed before storing.
- State machine:
  - EMPTY: in_ready=1, out_valid=0. Input fire -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Input and output fire together -> ONE; the main register takes the new entry.
    - Input fire only -> TWO; the new entry goes to the skid register.
    - Output fire only -> EMPTY.
  - TWO: in_ready=0, out_valid=1. Output fire -> ONE; skid moves to main.
- in_ready is a function of state only, with no combinational path from out_ready.
- Latency: an entry accepted on edge N is presented on out_* immediately after edge N. Throughput is 1 per cycle when out_ready is held at 1.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- flush: highest priority.
  - Next state is EMPTY.
  - An entry offered in the same cycle is dropped even if in_ready=1.
  - An output fire in the flush cycle is still counted as consumed by downstream.
- Reset (rst_n low, asynchronous, takes effect immediately):
  - Outputs: state EMPTY, out_valid=0, out_imm=0, out_tag=0, out_err=0, in_ready=1.
  - Internal: skid register cleared.
  - Reset mid-operation discards all held entries without further handshake.
- Data registers update only on accept or shift, so stored data does not toggle on idle cycles.

Decomposition:
- Shared package ysyx_24100006_id_pkg holds:
  - Type-code constants IMM_I, IMM_J, IMM_S, IMM_B, IMM_U, IMM_Z, IMM_SHAMT, IMM_ILL (3 bits).
  - State encodings ST_EMPTY, ST_ONE, ST_TWO.
- Sub-module ysyx_24100006_imm_extract: purely combinational, parameters XLEN and RVE_SHAMT6. Maps (inst, type) to (imm, err); it is reused by the decoder's non-pipelined paths.

Test Plan:
- XLEN=32:
  - in inst=0xFFF00093, type=000, tag=0x80000000, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_tag=0x80000000, out_err=0.
- XLEN=64:
  - inst=0xFE000EE3 type=011 -> out_imm=0xFFFFFFFFFFFFFFFC.
  - inst=0x80000037 type=100 -> 0xFFFFFFFF80000000.
  - inst=0x12345037 type=100 -> 0x0000000012345000.
- Z/SHAMT/illegal:
  - inst=0x000FD073 type=101 -> 0x1F.
  - XLEN=64 inst=0x03F0D093 type=110 -> 0x3F.
  - type=111 -> out_imm=0, out_err=1.
- Back-pressure: out_ready=0, offer tags A,B,C on consecutive cycles.
  - A and B are accepted; in_ready=0 from the cycle after B; C is held upstream.
  - Raising out_ready yields A,B,C in order at one per cycle, with no gaps after the first.
- Flush: state TWO with in_valid=1 and flush=1 -> next cycle out_valid=0, in_ready=1; the offered entry is never emitted.
- Async reset: drop rst_n mid-cycle in state TWO -> out_valid=0 and out_imm=0 before the next clock edge. After release, the first accepted entry emerges correctly after one cycle.
